// File: rtl/sprite_scan_pkg.sv
// Shared attribute field offsets, scanner state codes, the
// sprite load bundle and ROM address packing. No ports.
package sprite_scan_pkg;

   localparam int Y_LSB    = 0;
   localparam int X_LSB    = 9;
   localparam int COL_LSB  = 18;
   localparam int HF_BIT   = 26;
   localparam int VF_BIT   = 27;
   localparam int SZ_BIT   = 28;
   localparam int EN_BIT   = 29;
   localparam int CODE_LSB = 30;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_EMIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef struct packed {
      logic [8:0]  x;
      logic [7:0]  color;
      logic        hflip;
      logic        size;
      logic [13:0] code;
      logic [4:0]  row;
   } spr_load_t;

   function automatic logic [20:0] rom_addr(
      input logic [13:0] code,
      input logic [4:0]  row,
      input logic [1:0]  ch
   );
      return {code, row, ch};
   endfunction

endpackage

// File: rtl/sprite_chunk_emitter.sv
// Tick divider plus per-sprite chunk sequencer driving LACH/CARY/HEND,
// OC/HP/OHF and ROM_A/ROM_REQ. In: clk_24M, nRES, start, clr, ld.
// Out: chunk_fire/chunk_end/spr_end status and the emit outputs.
module sprite_chunk_emitter
   import sprite_scan_pkg::*;
#(
   parameter int CHUNK_TICKS = 4
) (
   input  logic        clk_24M,
   input  logic        nRES,
   input  logic        start,
   input  logic        clr,
   input  spr_load_t   ld,
   output logic        chunk_fire,
   output logic        chunk_end,
   output logic        spr_end,
   output logic        LACH,
   output logic        CARY,
   output logic        HEND,
   output logic [7:0]  OC,
   output logic [8:0]  HP,
   output logic        OHF,
   output logic [20:0] ROM_A,
   output logic        ROM_REQ
);

   localparam int TW =
      (CHUNK_TICKS > 1) ? $clog2(CHUNK_TICKS) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CHUNK_TICKS - 1);

   logic          tick_q;
   logic          active;
   spr_load_t     cur;
   logic [1:0]    c;
   logic [1:0]    c_last;
   logic [1:0]    romchunk;
   logic [TW-1:0] tcnt;

   assign c_last     = cur.size ? 2'd3 : 2'd1;
   assign romchunk   = cur.hflip ? c_last - c : c;
   assign chunk_fire = active & tick_q & (tcnt == '0);
   assign chunk_end  = active & tick_q & (tcnt == T_LAST);
   assign spr_end    = chunk_end & (c == c_last);

   always_ff @(posedge clk_24M or negedge nRES) begin
      if (!nRES) begin
         tick_q  <= 1'b0;
         active  <= 1'b0;
         cur     <= '0;
         c       <= '0;
         tcnt    <= '0;
         LACH    <= 1'b0;
         CARY    <= 1'b0;
         HEND    <= 1'b0;
         OC      <= '0;
         HP      <= '0;
         OHF     <= 1'b0;
         ROM_A   <= '0;
         ROM_REQ <= 1'b0;
      end else begin
         tick_q <= ~tick_q;
         if (clr) begin
            active  <= 1'b0;
            LACH    <= 1'b0;
            CARY    <= 1'b0;
            HEND    <= 1'b0;
            ROM_REQ <= 1'b0;
         end else begin
            if (tick_q) begin
               // pulses live exactly one tick
               LACH    <= 1'b0;
               CARY    <= 1'b0;
               HEND    <= 1'b0;
               ROM_REQ <= 1'b0;
               if (chunk_fire) begin
                  CARY    <= 1'b1;
                  ROM_REQ <= 1'b1;
                  LACH    <= (c == 2'd0);
                  HEND    <= (c == c_last);
                  HP      <= cur.x + {4'd0, c, 3'd0};
                  ROM_A   <= rom_addr(cur.code, cur.row,
                                      romchunk);
                  if (c == 2'd0) begin
                     OC  <= cur.color;
                     OHF <= cur.hflip;
                  end
               end
               if (active) begin
                  if (chunk_end) begin
                     tcnt <= '0;
                     c    <= c + 2'd1;
                     if (spr_end)
                        active <= 1'b0;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
            end
            if (start) begin
               cur    <= ld;
               active <= 1'b1;
               c      <= '0;
               tcnt   <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-line sprite attribute scan: fetch, hit test, chunk emission.
// In: clk_24M, nRES, LINE_START, LINE, ATTR_D. Out: ATTR_A, emit bus, BUSY, OVF.
module sprite_line_scanner
   import sprite_scan_pkg::*;
#(
   parameter int N_SPR       = 128,
   parameter int MAX_CHUNKS  = 128,
   parameter int CHUNK_TICKS = 4
) (
   input  logic                     clk_24M,
   input  logic                     nRES,
   input  logic                     LINE_START,
   input  logic [8:0]               LINE,
   output logic [$clog2(N_SPR)-1:0] ATTR_A,
   input  logic [47:0]              ATTR_D,
   output logic                     LACH,
   output logic                     CARY,
   output logic                     HEND,
   output logic [7:0]               OC,
   output logic [8:0]               HP,
   output logic                     OHF,
   output logic [20:0]              ROM_A,
   output logic                     ROM_REQ,
   output logic                     BUSY,
   output logic                     OVF
);

   localparam int IW = $clog2(N_SPR);
   localparam int CW = $clog2(MAX_CHUNKS) + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_SPR - 1);
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_CHUNKS);

   logic [2:0]    state;
   logic [IW-1:0] idx;
   logic [8:0]    line_q;
   logic [CW-1:0] cnt;
   logic [8:0]    dy;
   logic          big;
   logic          hit;
   logic [4:0]    hm1;
   logic [4:0]    row_raw;
   spr_load_t     ld;
   logic          start;
   logic          clr;
   logic          chunk_fire;
   logic          chunk_end;
   logic          spr_end;
   logic          ovf_hit;
   logic          unused_bits;

   assign ATTR_A      = idx;
   assign unused_bits = ^ATTR_D[47:44];

   always_comb begin
      // 9-bit subtraction gives the wrapped distance below Y
      dy       = line_q - ATTR_D[Y_LSB +: 9];
      big      = ATTR_D[SZ_BIT];
      hit      = ATTR_D[EN_BIT] &
                 (dy < (big ? 9'd32 : 9'd16));
      hm1      = big ? 5'd31 : 5'd15;
      row_raw  = ATTR_D[VF_BIT] ? hm1 - dy[4:0] : dy[4:0];
      ld.x     = ATTR_D[X_LSB +: 9];
      ld.color = ATTR_D[COL_LSB +: 8];
      ld.hflip = ATTR_D[HF_BIT];
      ld.size  = big;
      ld.code  = ATTR_D[CODE_LSB +: 14];
      ld.row   = {row_raw[4] & big, row_raw[3:0]};
   end

   assign start   = (state == S_CHECK) & hit & ~LINE_START;
   assign ovf_hit = chunk_end & (cnt == MAX_CNT);
   assign clr     = LINE_START | ((state == S_EMIT) & ovf_hit);

   always_ff @(posedge clk_24M or negedge nRES) begin
      if (!nRES) begin
         state  <= S_IDLE;
         idx    <= '0;
         line_q <= '0;
         cnt    <= '0;
         BUSY   <= 1'b0;
         OVF    <= 1'b0;
      end else if (LINE_START) begin
         state  <= S_FETCH;
         idx    <= '0;
         line_q <= LINE;
         cnt    <= '0;
         BUSY   <= 1'b1;
         OVF    <= 1'b0;
      end else begin
         unique case (state)
            S_FETCH: state <= S_CHECK;
            S_CHECK: begin
               if (hit) begin
                  state <= S_EMIT;
               end else if (idx == LAST_IDX) begin
                  state <= S_DONE;
                  BUSY  <= 1'b0;
               end else begin
                  idx   <= idx + IW'(1);
                  state <= S_FETCH;
               end
            end
            S_EMIT: begin
               if (chunk_fire)
                  cnt <= cnt + CW'(1);
               if (ovf_hit) begin
                  OVF   <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= S_DONE;
               end else if (spr_end) begin
                  if (idx == LAST_IDX) begin
                     state <= S_DONE;
                     BUSY  <= 1'b0;
                  end else begin
                     idx   <= idx + IW'(1);
                     state <= S_FETCH;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   sprite_chunk_emitter #(
      .CHUNK_TICKS (CHUNK_TICKS)
   ) u_emit (
      .clk_24M    (clk_24M),
      .nRES       (nRES),
      .start      (start),
      .clr        (clr),
      .ld         (ld),
      .chunk_fire (chunk_fire),
      .chunk_end  (chunk_end),
      .spr_end    (spr_end),
      .LACH       (LACH),
      .CARY       (CARY),
      .HEND       (HEND),
      .OC         (OC),
      .HP         (HP),
      .OHF        (OHF),
      .ROM_A      (ROM_A),
      .ROM_REQ    (ROM_REQ)
   );

endmodule
